// File: rtl/usb_tx_control_fsm.sv
// usb_tx_control_fsm: USB packet transmit sequencer (SYNC, PID, payload, CRC16, EOP, idle-J).
// Define USB_TX_DATA_TOGGLE_EN to alternate the DATA0/DATA1 PID between DATA packets.
module usb_tx_control_fsm #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [2:0]  tx_packet,
  input  logic        tx_start,
  input  logic [6:0]  buffer_occupancy,
  input  logic [7:0]  tx_data,
  input  logic [15:0] crc16,
  input  logic        shift_en,
  input  logic        byte_done,
  output logic [7:0]  tx_byte,
  output logic        load_byte,
  output logic        get_tx_data,
  output logic        clear_crc,
  output logic        crc_en,
  output logic        send_eop,
  output logic        tx_busy,
  output logic        tx_error
);
  typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, IDLE_J, ERROR} state_t;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [2:0] PKT_DATA = 3'd1;
  state_t state, state_n;
  logic [2:0] pkt, pkt_n;
  logic [6:0] cnt, cnt_n;
  logic eop_half, eop_half_n;
  logic [7:0] byte_n, data_pid;
  logic load_n, get_n, clr_n, legal;
`ifdef USB_TX_DATA_TOGGLE_EN
  logic toggle;
  assign data_pid = toggle ? 8'h4B : 8'hC3;
  always_ff @(posedge clk) begin
    if (!n_rst) toggle <= 1'b0;
    else if (state == EOP && state_n == IDLE_J && pkt == PKT_DATA) toggle <= ~toggle;
  end
`else
  assign data_pid = 8'hC3;
`endif
  assign legal = tx_packet inside {3'd1, 3'd4, 3'd5, 3'd7};
  // Outputs are registered from the next state, so every strobe lands in the first cycle of its state.
  always_comb begin
    state_n = state;
    pkt_n = pkt;
    cnt_n = cnt;
    byte_n = tx_byte;
    load_n = 1'b0;
    get_n = 1'b0;
    clr_n = 1'b0;
    eop_half_n = state == EOP ? (eop_half || shift_en) : 1'b0;
    case (state)
      IDLE: if (tx_start && legal) begin
        pkt_n = tx_packet;
        cnt_n = tx_packet == PKT_DATA ? buffer_occupancy : 7'd0;
        if (tx_packet == PKT_DATA && {1'b0, buffer_occupancy} > MAX_LEN) state_n = ERROR;
        else begin
          state_n = SYNC;
          load_n = 1'b1;
          byte_n = 8'h80;
        end
      end
      SYNC: if (byte_done) begin
        state_n = PID;
        load_n = 1'b1;
        clr_n = 1'b1;
        byte_n = pkt == PKT_DATA ? data_pid : pkt == 3'd4 ? 8'hD2 : pkt == 3'd5 ? 8'h5A : 8'h1E;
      end
      PID, DATA: if (byte_done) begin
        if (cnt != 7'd0) begin
          state_n = DATA;
          load_n = 1'b1;
          get_n = 1'b1;
          byte_n = tx_data;
          cnt_n = cnt - 7'd1;
        end else if (pkt == PKT_DATA) begin
          state_n = CRC_LO;
          load_n = 1'b1;
          byte_n = crc16[7:0];
        end else state_n = EOP;
      end
      CRC_LO: if (byte_done) begin
        state_n = CRC_HI;
        load_n = 1'b1;
        byte_n = crc16[15:8];
      end
      CRC_HI: if (byte_done) state_n = EOP;
      EOP: if (shift_en && eop_half) state_n = IDLE_J;
      IDLE_J: if (shift_en) state_n = IDLE;
      ERROR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      pkt <= '0;
      cnt <= '0;
      eop_half <= 1'b0;
      tx_byte <= '0;
      load_byte <= 1'b0;
      get_tx_data <= 1'b0;
      clear_crc <= 1'b0;
      crc_en <= 1'b0;
      send_eop <= 1'b0;
      tx_busy <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state <= state_n;
      pkt <= pkt_n;
      cnt <= cnt_n;
      eop_half <= eop_half_n;
      tx_byte <= byte_n;
      load_byte <= load_n;
      get_tx_data <= get_n;
      clear_crc <= clr_n;
      crc_en <= state_n == DATA;
      send_eop <= state_n == EOP;
      tx_busy <= !(state_n inside {IDLE, ERROR});
      tx_error <= state_n == ERROR;
    end
  end
endmodule

// File: tb/tb_usb_tx_control_fsm.sv
// tb_usb_tx_control_fsm: scoreboard bench; expected byte stream per packet is queued, a monitor checks each load.
module tb_usb_tx_control_fsm;
  localparam int MAXP = 64;
  logic clk, n_rst, tx_start, shift_en, byte_done;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_data, tx_byte;
  logic [15:0] crc16;
  logic load_byte, get_tx_data, clear_crc, crc_en, send_eop, tx_busy, tx_error;

  usb_tx_control_fsm #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .tx_start(tx_start),
    .buffer_occupancy(buffer_occupancy), .tx_data(tx_data), .crc16(crc16),
    .shift_en(shift_en), .byte_done(byte_done), .tx_byte(tx_byte), .load_byte(load_byte),
    .get_tx_data(get_tx_data), .clear_crc(clear_crc), .crc_en(crc_en), .send_eop(send_eop),
    .tx_busy(tx_busy), .tx_error(tx_error)
  );

  typedef struct packed {logic [7:0] b; logic pay; logic pid;} exp_t;
  exp_t exp_q[$];
  logic [7:0] pay_q[$], buf_q[$];
  int vectors = 0, miscompares = 0;
  int n_get = 0, n_eop = 0, n_j = 0, n_err = 0;
  bit mon_en = 0, tog_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input logic pay, input logic pid);
    exp_t e;
    e.b = b;
    e.pay = pay;
    e.pid = pid;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] pid_of(input logic [2:0] p);
    return p == 3'd1 ? (tog_m ? 8'h4B : 8'hC3) : p == 3'd4 ? 8'hD2 : p == 3'd5 ? 8'h5A : 8'h1E;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    shift_en = 0;
    forever begin
      @(posedge clk);
      #1 shift_en = ($urandom_range(0, 2) == 0);
    end
  end

  // Shifter stand-in: byte_done after each load, plus stray pulses during EOP that must be ignored.
  initial begin
    byte_done = 0;
    forever begin
      @(negedge clk);
      if (load_byte === 1'b1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 byte_done = 1;
        @(posedge clk);
        #1 byte_done = 0;
      end else if (send_eop === 1'b1 && $urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1 byte_done = 1;
        @(posedge clk);
        #1 byte_done = 0;
      end
    end
  end

  initial begin
    tx_data = 0;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && get_tx_data === 1'b1 && buf_q.size() > 0) void'(buf_q.pop_front());
      tx_data = buf_q.size() > 0 ? buf_q[0] : 8'h00;
    end
  end

  initial begin
    logic [7:0] last_byte;
    bit prev_eop, in_j;
    int jc;
    exp_t e;
    last_byte = 0; prev_eop = 0; in_j = 0; jc = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        in_j = 0; jc = 0; last_byte = 8'h00; prev_eop = 0;
      end else begin
        if (load_byte) begin
          if (exp_q.size() == 0) chk("load_byte_unexpected", load_byte, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("tx_byte", tx_byte, e.b);
            chk("get_tx_data_with_load", get_tx_data, e.pay);
            chk("crc_en_at_load", crc_en, e.pay);
            chk("clear_crc_at_load", clear_crc, e.pid);
          end
          last_byte = tx_byte;
        end else begin
          chk("tx_byte_hold", tx_byte, last_byte);
          chk("stray_strobe", {get_tx_data, clear_crc}, 2'b00);
        end
        n_get += int'(get_tx_data);
        n_err += int'(tx_error);
        n_eop += int'(send_eop && shift_en);
        if (prev_eop && !send_eop && tx_busy) in_j = 1;
        if (in_j) begin
          if (!tx_busy) begin n_j += jc; in_j = 0; jc = 0; end
          else if (shift_en) jc++;
        end
        prev_eop = send_eop;
      end
    end
  end

  task automatic send(input logic [2:0] p, input int occ, input logic [15:0] crc);
    bit legal, err, ok;
    int g0, e0, j0, x0, k;
    legal = p inside {3'd1, 3'd4, 3'd5, 3'd7};
    err = legal && p == 3'd1 && occ > MAXP;
    ok = legal && !err;
    buf_q.delete();
    if (ok) begin
      push_exp(8'h80, 0, 0);
      push_exp(pid_of(p), 0, 1);
      if (p == 3'd1) begin
        while (pay_q.size() < occ) pay_q.push_back(8'($urandom));
        foreach (pay_q[i]) begin
          push_exp(pay_q[i], 1, 0);
          buf_q.push_back(pay_q[i]);
        end
        push_exp(crc[7:0], 0, 0);
        push_exp(crc[15:8], 0, 0);
      end
    end
    pay_q.delete();
    g0 = n_get; e0 = n_eop; j0 = n_j; x0 = n_err;
    @(posedge clk);
    #1 tx_packet = p; buffer_occupancy = 7'(occ); crc16 = crc; tx_start = 1;
    @(posedge clk);
    #1 tx_start = 0; buffer_occupancy = 7'($urandom);
    @(negedge clk);
    chk("tx_busy_after_start", tx_busy, ok);
    k = 0;
    while (k < 3000 && (k < 4 || tx_busy || exp_q.size() != 0)) begin
      @(posedge clk);
      #1 k++;
      if (k == 3 && tx_busy) begin
        tx_packet = 3'd4; tx_start = 1;
        @(posedge clk);
        #1 tx_start = 0;
      end
    end
    @(negedge clk);
    #1;
    chk("packet_timeout", k >= 3000, 0);
    chk("bytes_outstanding", exp_q.size(), 0);
    chk("tx_busy_end", tx_busy, 0);
    chk("get_tx_data_count", n_get - g0, (ok && p == 3'd1) ? occ : 0);
    chk("eop_strobes", n_eop - e0, ok ? 2 : 0);
    chk("idle_j_strobes", n_j - j0, ok ? 1 : 0);
    chk("tx_error_cycles", n_err - x0, err ? 1 : 0);
`ifdef USB_TX_DATA_TOGGLE_EN
    if (ok && p == 3'd1) tog_m = !tog_m;
`endif
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_mid();
    int k;
    repeat (6) pay_q.push_back(8'($urandom));
    buf_q = pay_q;
    push_exp(8'h80, 0, 0);
    push_exp(pid_of(3'd1), 0, 1);
    foreach (pay_q[i]) push_exp(pay_q[i], 1, 0);
    pay_q.delete();
    @(posedge clk);
    #1 tx_packet = 3'd1; buffer_occupancy = 7'd6; crc16 = 16'h1234; tx_start = 1;
    @(posedge clk);
    #1 tx_start = 0;
    k = 0;
    while (!crc_en && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reached_data_state", crc_en, 1);
    n_rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_outputs", {tx_byte, load_byte, get_tx_data, clear_crc, crc_en, send_eop, tx_busy, tx_error}, 0);
    @(posedge clk);
    #1 n_rst = 1; exp_q.delete(); buf_q.delete(); tog_m = 0;
    @(negedge clk);
    chk("post_reset_strobes", {load_byte, get_tx_data, clear_crc}, 0);
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, occ;
    n_rst = 0; tx_start = 0; tx_packet = 0; buffer_occupancy = 0; crc16 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {tx_byte, load_byte, get_tx_data, clear_crc, crc_en, send_eop, tx_busy, tx_error}, 0);
    @(posedge clk);
    #1 n_rst = 1; mon_en = 1;
    @(negedge clk);
    chk("release_strobes", {load_byte, get_tx_data, clear_crc}, 0);
    send(3'd4, 0, 16'h0000);
    pay_q = '{8'h11, 8'h22, 8'h33};
    send(3'd1, 3, 16'hABCD);
    send(3'd1, 0, 16'h5A3C);
    send(3'd1, 65, 16'hFFFF);
    send(3'd1, 64, 16'h0F0F);
    send(3'd2, 5, 16'h1111);
    send(3'd5, 9, 16'h2222);
    send(3'd7, 0, 16'h3333);
    reset_mid();
    send(3'd1, 2, 16'h4444);
    send(3'd1, 1, 16'h5555);
    repeat (40) begin
      p = $urandom_range(0, 7);
      occ = p != 1 ? $urandom_range(0, 127) :
            $urandom_range(0, 9) == 0 ? $urandom_range(65, 127) : $urandom_range(0, 12);
      send(3'(p), occ, 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
